spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Register-access controller that sequences an SPI slave shifter, operating in the system `clk` domain.
- Synchronizes the shifter's word strobes and slave select, then decodes a command byte (R/W + start address).
- Drives a single-port register bus with auto-incrementing address, performing write bursts or prefetched read bursts.
- Sits between the SPI slave shifter and the block's configuration register file.

Parameters:
DATA_WDT, 8, SPI word width in bits; must be ≥ 4.
ADDR_WDT, 7, register address width; fixed to DATA_WDT-1.
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (ssel, rxRdy, txLoad); must be ≥ 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
ssel  in  1  raw slave select, active low, asynchronous to clk
rxRdy  in  1  raw word-received strobe from shifter, asynchronous; rising edge = new rxData
rxData  in  DATA_WDT  received word; stable ≥ 4 clk after rxRdy rise
txLoad  in  1  raw strobe from shifter, asynchronous; rising edge = txData consumed
txData  out  DATA_WDT  next word for shifter to transmit
regAddr  out  ADDR_WDT  register bus address
regWr  out  1  one-cycle write strobe
regWrData  out  DATA_WDT  write data, valid with regWr
regRd  out  1  one-cycle read strobe
regRdData  in  DATA_WDT  read data, valid exactly 1 clk after regRd
busy  out  1  high while a frame is active (state ≠ IDLE)
frameDone  out  1  one-cycle pulse at frame end (ssel deassert after ≥1 complete word)

Behaviour:
- Reset is synchronous and active-high.
- Reset values: txData=0, regAddr=0, regWr=0, regWrData=0, regRd=0, busy=0, frameDone=0; state IDLE; sync chains cleared.
- Synchronization and edge detection: ssel, rxRdy and txLoad each pass through SYNC_STAGES flops.
  - Edge detect uses one further registered copy.
  - rxEv = rxRdy rise; txEv = txLoad rise; selFall / selRise on the synchronized ssel.
- rxData handling: rxData is sampled into an internal register on the cycle rxEv is asserted. It is never used combinationally.
- State IDLE:
  - txData=0.
  - selFall → CMD; wordCnt cleared.
- State CMD:
  - txEv is ignored (word 0 transmits txData=0).
  - On rxEv: regAddr←rxData[ADDR_WDT-1:0].
  - If rxData[DATA_WDT-1]=0 → WRITE.
  - If rxData[DATA_WDT-1]=1 → RD_ISSUE.
- State WRITE:
  - Each rxEv: the next cycle asserts regWr=1 with regWrData=captured word at current regAddr.
  - regAddr increments the cycle after regWr.
- State RD_ISSUE:
  - regRd=1 for one cycle at regAddr → RD_CAP.
- State RD_CAP:
  - txData←regRdData.
  - regAddr increments → READ.
- State READ:
  - Each txEv → RD_ISSUE (prefetch of next word).
  - rxEv in READ (master dummy bytes) is ignored; no writes occur.
- Address arithmetic: regAddr wraps from 2^ADDR_WDT-1 to 0. No error is flagged.
- Frame timing:
  - The master leaves ≥ SYNC_STAGES+4 clk between the last sclk edge of the command byte and the first sclk edge of the next word. This gives the first read word time to reach txData.
  - Inter-word spacing within a burst is ≥ SYNC_STAGES+4 clk.
- Frame end: selRise in any non-IDLE state → IDLE on the next cycle.
  - regWr and regRd are forced 0 from that cycle.
  - A pending write whose rxEv has already been detected completes before IDLE.
  - A pending read capture is discarded.
  - frameDone pulses if wordCnt ≥ 1.
  - txData returns to 0.
- Simultaneous events: selRise has priority over rxEv/txEv in the same cycle; the rx/tx event is dropped.
- Reset mid-frame: everything returns to reset values.
  - Frame resumption is not attempted; a new selFall is required.
- busy: high in all states except IDLE.
- Strobe separation: regWr and regRd are never asserted in the same cycle.

Test Plan:
- Write burst: ssel low, words 0x05,0xA1,0xB2,0xC3 → regWr pulses at addr 0x05/0x06/0x07 with data 0xA1/0xB2/0xC3; regRd never asserted; frameDone once after ssel high.
- Read burst: regfile[0x10..0x12]=0x11,0x22,0x33; command 0x90 then 3 dummy words → MISO words 1..3 = 0x11,0x22,0x33; regRd at 0x10,0x11,0x12,0x13 (last is a prefetch).
- Address wrap: write command 0x7E, data 0x01,0x02,0x03 → writes at 0x7E,0x7F,0x00.
- Abort mid-word: write command 0x20, ssel raised after 4 bits of data word → no regWr; busy falls; frameDone pulses (wordCnt=1); next frame behaves normally.
- Collision: selRise and rxEv in the same cycle (forced at sync outputs) → no regWr; state IDLE.
- Reset mid-read: assert reset during READ → all outputs at reset values next cycle; the following frame with command 0x85 reads from 0x05 correctly.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Register-access controller that sits between an SPI slave shifter and a
// configuration register file. Each frame starts with a command byte:
// bit DATA_WDT-1 selects read (1) or write (0), and the low ADDR_WDT bits
// give the start address. Every following word then either writes the next
// register or returns the next register's contents. The address
// auto-increments and wraps. Reads are prefetched, so the next word is
// already in txData when the shifter loads it.
//
// Ports
//   clk        system clock
//   reset      synchronous reset, active-high
//   ssel       raw slave select, active low, asynchronous
//   rxRdy      raw word-received strobe, asynchronous (rise = rxData valid)
//   rxData     received word, stable >= 4 clk after rxRdy rise
//   txLoad     raw strobe, asynchronous (rise = txData consumed by shifter)
//   txData     next word for the shifter to transmit
//   regAddr    register bus address
//   regWr      one-cycle write strobe
//   regWrData  write data, valid with regWr
//   regRd      one-cycle read strobe
//   regRdData  read data, valid one clk after regRd
//   busy       high while a frame is active
//   frameDone  one-cycle pulse when a frame with >= 1 complete word ends
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int DATA_WDT    = 8,
    parameter int ADDR_WDT    = DATA_WDT - 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ssel,
    input  logic                rxRdy,
    input  logic [DATA_WDT-1:0] rxData,
    input  logic                txLoad,
    output logic [DATA_WDT-1:0] txData,
    output logic [ADDR_WDT-1:0] regAddr,
    output logic                regWr,
    output logic [DATA_WDT-1:0] regWrData,
    output logic                regRd,
    input  logic [DATA_WDT-1:0] regRdData,
    output logic                busy,
    output logic                frameDone
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_ISSUE,
        RD_CAP,
        READ
    } state_t;

    localparam int                N_SYNC   = 3;
    localparam logic [ADDR_WDT-1:0] ADDR_ONE = ADDR_WDT'(1);
    localparam logic [1:0]        CNT_MAX  = 2'd3;

    // ------------------------------------------------------------------
    // Synchronizers: bit 0 = ssel, bit 1 = rxRdy, bit 2 = txLoad.
    // Chains clear to 0. An idle-high ssel therefore shows a rise
    // right after reset, which is harmless because IDLE ignores it.
    // ------------------------------------------------------------------
    logic [N_SYNC-1:0] async_in;
    logic [N_SYNC-1:0] sync_q;
    logic [N_SYNC-1:0] sync_d_reg;
    logic [N_SYNC-1:0] rise;
    logic [N_SYNC-1:0] fall;

    assign async_in = {txLoad, rxRdy, ssel};

    generate
        for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
                end
            end

            assign sync_q[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d_reg <= '0;
        end else begin
            sync_d_reg <= sync_q;
        end
    end

    assign rise = sync_q & ~sync_d_reg;
    assign fall = ~sync_q & sync_d_reg;

    logic sel_fall;
    logic sel_rise;
    logic rx_ev;
    logic tx_ev;

    assign sel_fall = fall[0];
    assign sel_rise = rise[0];
    assign rx_ev    = rise[1];
    assign tx_ev    = rise[2];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t              state_reg,   state_next;
    logic [ADDR_WDT-1:0] addr_reg,    addr_next;
    logic [DATA_WDT-1:0] tx_reg,      tx_next;
    logic                wr_reg,      wr_next;
    logic [DATA_WDT-1:0] wr_data_reg, wr_data_next;
    logic [1:0]          cnt_reg,     cnt_next;   // saturating word count
    logic                done_reg,    done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            tx_reg      <= '0;
            wr_reg      <= 1'b0;
            wr_data_reg <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            tx_reg      <= tx_next;
            wr_reg      <= wr_next;
            wr_data_reg <= wr_data_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        tx_next      = tx_reg;
        wr_next      = 1'b0;
        wr_data_next = wr_data_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;

        // The address advances the cycle after each write strobe.
        if (wr_reg) begin
            addr_next = addr_reg + ADDR_ONE;
        end

        if (state_reg != IDLE && rx_ev && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 2'd1;
        end

        case (state_reg)
            IDLE: begin
                tx_next = '0;
                if (sel_fall) begin
                    state_next = CMD;
                    cnt_next   = '0;
                end
            end
            CMD: begin
                // The command word goes out as txData=0, so txEv is ignored.
                if (rx_ev) begin
                    addr_next  = rxData[ADDR_WDT-1:0];
                    state_next = rxData[DATA_WDT-1] ? RD_ISSUE : WRITE;
                end
            end
            WRITE: begin
                if (rx_ev) begin
                    wr_next      = 1'b1;
                    wr_data_next = rxData;
                end
            end
            RD_ISSUE: begin
                state_next = RD_CAP;
            end
            RD_CAP: begin
                tx_next    = regRdData;
                addr_next  = addr_reg + ADDR_ONE;
                state_next = READ;
            end
            READ: begin
                // The shifter just took txData, so prefetch the next word.
                // Dummy MOSI words are ignored here.
                if (tx_ev) begin
                    state_next = RD_ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Frame end wins over any same-cycle rx/tx event. A write strobe
        // already on the bus still completes, so its address step is kept.
        // A read capture in flight is simply dropped.
        if (state_reg != IDLE && sel_rise) begin
            state_next   = IDLE;
            wr_next      = 1'b0;
            wr_data_next = wr_data_reg;
            tx_next      = '0;
            addr_next    = wr_reg ? (addr_reg + ADDR_ONE) : addr_reg;
            cnt_next     = cnt_reg;
            done_next    = (cnt_reg != 2'd0);
        end
    end

    assign txData    = tx_reg;
    assign regAddr   = addr_reg;
    assign regWr     = wr_reg;
    assign regWrData = wr_data_reg;
    assign regRd     = (state_reg == RD_ISSUE);
    assign busy      = (state_reg != IDLE);
    assign frameDone = done_reg;

endmodule
